// File: rtl/arbitro_rr_pkg.sv
// Shared router definitions: direction indices, arbiter defaults and
// the round-robin priority search helper used by the output-port arbiters.
package arbitro_rr_pkg;

  // Request-bit positions of each router direction
  typedef enum logic [2:0] {
    DIR_CORE     = 3'd0,
    DIR_DIREITA  = 3'd1,
    DIR_ESQUERDA = 3'd2,
    DIR_BAIXO    = 3'd3,
    DIR_CIMA     = 3'd4
  } dir_e;

  localparam int N_PORTAS_DEF   = 5;
  localparam int WAIT_W_DEF     = 4;
  localparam int STARVE_LIM_DEF = 8;

  // Widest requester vector the search helper handles
  localparam int MAX_PORTAS = 16;
  localparam int IDX_W      = 4;

  // Result of one priority search
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } busca_t;

  // Walk ptr, ptr-1, ..., 0, n-1, ..., ptr+1 and return the first set
  // bit of mask. n and ptr are expected in range (ptr < n <= MAX_PORTAS).
  function automatic busca_t busca_prioridade(
    input logic [MAX_PORTAS-1:0] mask,
    input int                    n,
    input int                    ptr
  );
    busca_t r;
    int     pos;
    r   = '0;
    pos = 0;
    for (int k = 0; k < MAX_PORTAS; k++) begin
      if (k < n) begin
        if (ptr >= k) begin
          pos = ptr - k;
        end else begin
          pos = ptr + n - k;
        end
        if (!r.found && mask[pos[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = pos[IDX_W-1:0];
        end else begin
          r = r;
        end
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arbitro_rr_contador_espera.sv
// Per-requester wait counter with registered starvation flag.
// The counter saturates at all-ones so a long wait never wraps back
// to a small value and silently clears the flag.
module contador_espera
  import arbitro_rr_pkg::*;
#(
  parameter int WAIT_W     = WAIT_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic grant,
  output logic starve
);

  localparam logic [WAIT_W-1:0] CNT_MAX = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] LIM     = WAIT_W'(STARVE_LIM);

  logic [WAIT_W-1:0] count;
  logic [WAIT_W-1:0] count_next;

  // Next wait count: clear on grant or idle, else saturating increment
  always_comb begin
    count_next = count;
    if (grant || !req) begin
      count_next = '0;
    end else if (count != CNT_MAX) begin
      count_next = count + WAIT_W'(1);
    end else begin
      count_next = count;
    end
  end

  // Counter and starvation flag registers, flag follows the updated count
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      starve <= 1'b0;
    end else begin
      count  <= count_next;
      starve <= (count_next >= LIM);
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter for one router output port with starvation override.
// Grant is combinational from req and registered state so a request that
// disappears is never granted on stale information.
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int N_PORTAS   = N_PORTAS_DEF,
  parameter int WAIT_W     = WAIT_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_PORTAS-1:0] req,
  output logic [N_PORTAS-1:0] grant,
  output logic [N_PORTAS-1:0] starve,
  output logic                busy
);

  localparam int PTR_W = (N_PORTAS > 1) ? $clog2(N_PORTAS) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_PORTAS - 1);

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_next;
  logic [MAX_PORTAS-1:0] mask_normal;
  logic [MAX_PORTAS-1:0] mask_fome;
  busca_t                res_normal;
  busca_t                res_fome;
  busca_t                sel;

  // Index just below idx in circular order; the winner drops to lowest priority
  function automatic logic [PTR_W-1:0] anterior(input logic [IDX_W-1:0] idx);
    logic [PTR_W-1:0] r;
    if (idx == {IDX_W{1'b0}}) begin
      r = PTR_RST;
    end else begin
      r = PTR_W'(idx - IDX_W'(1));
    end
    return r;
  endfunction

  // Both searches run every cycle; starving requesters win when present
  always_comb begin
    mask_normal = '0;
    mask_fome   = '0;
    grant       = '0;
    ptr_next    = ptr;
    mask_normal[N_PORTAS-1:0] = req;
    mask_fome[N_PORTAS-1:0]   = req & starve;
    res_normal = busca_prioridade(mask_normal, N_PORTAS, int'(ptr));
    res_fome   = busca_prioridade(mask_fome, N_PORTAS, int'(ptr));
    if (res_fome.found) begin
      sel = res_fome;
    end else begin
      sel = res_normal;
    end
    for (int i = 0; i < N_PORTAS; i++) begin
      grant[i] = sel.found && (sel.idx == IDX_W'(i));
    end
    if (sel.found) begin
      ptr_next = anterior(sel.idx);
    end else begin
      ptr_next = ptr;
    end
    busy = |grant;
  end

  // Rotation pointer; reset puts cima at the top of the search
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PTR_RST;
    end else begin
      ptr <= ptr_next;
    end
  end

  // One wait counter / starvation flag per requester
  for (genvar i = 0; i < N_PORTAS; i++) begin : g_cnt
    contador_espera #(
      .WAIT_W     (WAIT_W),
      .STARVE_LIM (STARVE_LIM)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .req    (req[i]),
      .grant  (grant[i]),
      .starve (starve[i])
    );
  end

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: rotation, wrap, reset behaviour,
// starvation override and wait-counter saturation.
module tb_arbitro_rr;

  logic       clk;
  logic       rst;
  logic [4:0] req_a;
  logic [4:0] grant_a;
  logic [4:0] starve_a;
  logic       busy_a;
  logic [4:0] req_b;
  logic [4:0] grant_b;
  logic [4:0] starve_b;
  logic       busy_b;
  logic       ce_req;
  logic       ce_grant;
  logic       ce_starve;

  int vectors;
  int errs;

  logic [4:0] exp_rot [5];

  arbitro_rr dut_a (
    .clk    (clk),
    .rst    (rst),
    .req    (req_a),
    .grant  (grant_a),
    .starve (starve_a),
    .busy   (busy_a)
  );

  arbitro_rr #(.N_PORTAS(5), .WAIT_W(4), .STARVE_LIM(2)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .req    (req_b),
    .grant  (grant_b),
    .starve (starve_b),
    .busy   (busy_b)
  );

  contador_espera #(.WAIT_W(4), .STARVE_LIM(8)) u_ce (
    .clk    (clk),
    .rst    (rst),
    .req    (ce_req),
    .grant  (ce_grant),
    .starve (ce_starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle at the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors  = 0;
    errs     = 0;
    exp_rot  = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    rst      = 1'b1;
    req_a    = 5'b00000;
    req_b    = 5'b00000;
    ce_req   = 1'b0;
    ce_grant = 1'b0;
    cyc();
    cyc();

    // reset state
    #1;
    chk("rst_grant", 32'(grant_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_starve", 32'(starve_a), 32'd0);
    req_a = 5'b11111;
    #1;
    chk("rst_grant_req", 32'(grant_a), 32'b10000);

    // five requesters held: 4,3,2,1,0
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rot5_grant", 32'(grant_a), 32'(exp_rot[k]));
      chk("rot5_busy", 32'(busy_a), 32'd1);
      cyc();
    end
    chk("rot5_grant_wrap", 32'(grant_a), 32'b10000);
    chk("rot5_starve", 32'(starve_a), 32'd0);

    // two requesters alternate
    rst = 1'b1;
    req_a = 5'b00101;
    cyc();
    rst = 1'b0;
    #1; chk("alt_g0", 32'(grant_a), 32'b00100); cyc();
    #1; chk("alt_g1", 32'(grant_a), 32'b00001); cyc();
    #1; chk("alt_g2", 32'(grant_a), 32'b00100); cyc();
    #1; chk("alt_g3", 32'(grant_a), 32'b00001);

    // wrap 0 -> 4
    rst = 1'b1;
    req_a = 5'b01000;
    cyc();
    rst = 1'b0;
    #1; chk("wrap_g0", 32'(grant_a), 32'b01000); cyc();
    req_a = 5'b01001;
    #1; chk("wrap_g1", 32'(grant_a), 32'b00001); cyc();
    #1; chk("wrap_g2", 32'(grant_a), 32'b01000);

    // single requester granted every cycle
    req_a = 5'b00010;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1; chk("single_grant", 32'(grant_a), 32'b00010);
    end

    // reset mid-sequence discards rotation
    rst = 1'b1;
    req_a = 5'b11111;
    cyc();
    rst = 1'b0;
    #1; chk("mid_g0", 32'(grant_a), 32'b10000); cyc();
    #1; chk("mid_g1", 32'(grant_a), 32'b01000); cyc();
    #1; chk("mid_g2", 32'(grant_a), 32'b00100); cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_onehot", 32'($onehot(grant_a)), 32'd1);
    chk("mid_rst_busy", 32'(busy_a), 32'd1);
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_after_grant", 32'(grant_a), 32'b10000);
    chk("mid_after_starve", 32'(starve_a), 32'd0);
    cyc();
    req_a = 5'b00000;
    #1;
    chk("idle_grant", 32'(grant_a), 32'd0);
    chk("idle_busy", 32'(busy_a), 32'd0);

    // starvation override, STARVE_LIM = 2, pointer pinned at 4
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    force dut_b.ptr = 3'd4;
    req_b = 5'b10001;
    #1;
    chk("starv_g0", 32'(grant_b), 32'b10000);
    cyc();
    #1;
    chk("starv_s1", 32'(starve_b), 32'd0);
    chk("starv_g1", 32'(grant_b), 32'b10000);
    cyc();
    #1;
    chk("starv_s2", 32'(starve_b), 32'b00001);
    chk("starv_override", 32'(grant_b), 32'b00001);
    chk("starv_busy", 32'(busy_b), 32'd1);
    cyc();
    release dut_b.ptr;
    #1;
    chk("starv_clear", 32'(starve_b), 32'd0);
    req_b = 5'b00000;

    // wait counter saturates without wrapping, grant masked
    ce_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      #1;
      chk("sat_count", 32'(u_ce.count), (k < 15) ? 32'(k) : 32'd15);
      chk("sat_starve", 32'(ce_starve), (k >= 8) ? 32'd1 : 32'd0);
    end
    ce_req = 1'b0;
    cyc();
    #1;
    chk("sat_drop_starve", 32'(ce_starve), 32'd0);
    chk("sat_drop_count", 32'(u_ce.count), 32'd0);
    ce_req   = 1'b1;
    ce_grant = 1'b1;
    cyc();
    #1;
    chk("grant_clears_count", 32'(u_ce.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/arbitro_rr.md
ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 Parameter N_PORTAS, default 5, number of requesters; bit 4 = cima, 3 = baixo, 2 = esquerda, 1 = direita, 0 = core.
REQ-002 Parameter WAIT_W, default 4, width of each per-requester wait counter.
REQ-003 Parameter STARVE_LIM, default 8, wait count at or above which a requester is flagged starving; SHALL be ≤ 2^WAIT_W−1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N_PORTAS  request vector for one output port, produced by the router control block.
REQ-007 grant  output  N_PORTAS  one-hot or zero grant vector, consumed by the router control block.
REQ-008 starve  output  N_PORTAS  per-requester starvation flag, registered.
REQ-009 busy  output  1  high when any grant bit is high.

Function
REQ-010 grant SHALL be combinational from the current req and the registered state; zero-cycle request-to-grant latency, so a request dropped because a queue emptied or filled never receives a stale grant.
REQ-011 grant SHALL have at most one bit set; grant SHALL be 0 when req = 0; grant[i] SHALL be 1 only if req[i] = 1.
REQ-012 Registered pointer ptr (0..N_PORTAS−1) SHALL mark the highest-priority index; search order ptr, ptr−1, …, 0, N_PORTAS−1, …, ptr+1.
REQ-013 Normal mode: grant goes to the first requesting index in search order.
REQ-014 Starvation override: when any bit of starve & req is set, grant goes to the first index in search order with starve[i] & req[i], ignoring non-starving requesters.
REQ-015 On a clock edge with grant[i] = 1, ptr SHALL become (i−1) mod N_PORTAS, wrapping 0 → N_PORTAS−1; with grant = 0, ptr SHALL hold.
REQ-016 Per requester i, wait counter SHALL:
- clear when grant[i] = 1 or req[i] = 0;
- else increment by 1, saturating at 2^WAIT_W−1 with no wrap.
REQ-017 starve[i] SHALL be registered: 1 on the edge where the updated wait counter is ≥ STARVE_LIM, else 0.
REQ-018 A single requester held continuously SHALL be granted every cycle; grant is per packet and repeats each cycle while req stays high.
REQ-019 Five requesters held continuously SHALL be granted in the order 4, 3, 2, 1, 0, 4, … with one grant per cycle.
REQ-020 busy SHALL equal the OR-reduction of grant.

Reset
REQ-021 On rst = 1 at a clock edge:
- ptr SHALL become N_PORTAS−1 (cima first, matching the router's fixed selector priority);
- all wait counters SHALL clear;
- starve SHALL become 0.
REQ-022 During reset, grant SHALL still follow REQ-010..REQ-014 using the reset-pending state, so it is never X; the register update is suppressed.
REQ-023 Reset asserted mid-sequence SHALL discard rotation history; the first grant after reset follows ptr = N_PORTAS−1.

Structure
REQ-024 Direction indices (CIMA = 4 … CORE = 0 as request-bit positions), N_PORTAS and STARVE_LIM defaults SHALL live in the shared router package used by the control block and crossbar.
REQ-025 Priority search SHALL be a combinational function reused for normal and override masks.
REQ-026 The wait counter plus starve flag SHALL be one sub-module, contador_espera, instantiated N_PORTAS times.
REQ-027 The router instantiates one arbitro_rr per output port (5 total).

Verification
REQ-028 Reset, then req = 5'b11111 for 5 cycles → grant = 10000, 01000, 00100, 00010, 00001; busy = 1 throughout.
REQ-029 Reset, req = 5'b00101 held 4 cycles → grant = 00100, 00001, 00100, 00001.
REQ-030 After grant 01000 (ptr = 2), req = 5'b01001 → grant = 00001; next cycle with the same req → grant = 01000 (wrap 0 → 4).
REQ-031 Starvation check, STARVE_LIM = 2:
- req = 5'b10001 with bit 0 masked (test force of ptr to 4 each cycle) for 2 cycles → starve[0] = 1;
- then req = 5'b10001 → grant = 00001 despite ptr = 4;
- next cycle starve[0] = 0.
REQ-032 req[2] held 20 cycles without grant (forced mask), WAIT_W = 4 → counter saturates at 15 and does not wrap; starve[2] stays 1; dropping req[2] → starve[2] = 0 next edge.
REQ-033 Assert rst while ptr = 1 and req = 5'b11111 → first cycle after release grant = 10000; req = 0 → grant = 0, busy = 0.
